branch_resolve_unit: RTL

- Parametrised successor to the single-cycle zero-compare branch logic: resolves all conditional branch types (two-operand, zero-compare, unsigned) on XLEN-bit operands.
- Adds a registered valid/ready result stage, a PC-indexed 2-bit branch history table (BHT) for prediction, and mispredict detection with a saturating mispredict counter.
- Sits between decode/register read and the fetch redirect logic.

---
 rtl/branch_resolve_unit_pkg.sv | 44 ++++
 rtl/branch_resolve_unit_cond_eval.sv | 43 ++++
 rtl/branch_resolve_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit.
//   - br_op encodings (BR_BEQ .. BR_BGEU)
//   - 2-bit BHT counter type, its reset value and its saturating update
//   - clog2 helper used to size the BHT index
package branch_resolve_unit_pkg;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BLTZ = 3'd2;
    localparam logic [2:0] BR_BGEZ = 3'd3;
    localparam logic [2:0] BR_BLEZ = 3'd4;
    localparam logic [2:0] BR_BGTZ = 3'd5;
    localparam logic [2:0] BR_BLTU = 3'd6;
    localparam logic [2:0] BR_BGEU = 3'd7;

    typedef logic [1:0] bht_ctr_t;

    // Weakly not-taken.
    localparam bht_ctr_t BHT_RESET = 2'b01;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Saturating 2-bit counter step: up on taken, down on not taken.
    function automatic bht_ctr_t bht_step(input bht_ctr_t cur, input logic taken);
        bht_ctr_t res;
        res = cur;
        if (taken) begin
            if (cur != 2'b11) res = cur + 2'd1;
        end else begin
            if (cur != 2'b00) res = cur - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational branch condition evaluator.
// Ports:
//   br_op  : branch operation (BR_* encodings)
//   rs_val : first operand
//   rt_val : second operand (only used by BEQ/BNE/BLTU/BGEU)
//   taken  : resolved branch direction
module branch_cond_eval
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      br_op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            taken
);

    logic rs_neg;
    logic rs_zero;
    logic rs_eq_rt;
    logic rs_ltu_rt;

    assign rs_neg    = rs_val[XLEN-1];
    assign rs_zero   = (rs_val == '0);
    assign rs_eq_rt  = (rs_val == rt_val);
    assign rs_ltu_rt = (rs_val < rt_val);

    always_comb begin
        taken = 1'b0;
        case (br_op)
            BR_BEQ:  taken = rs_eq_rt;
            BR_BNE:  taken = !rs_eq_rt;
            BR_BLTZ: taken = rs_neg;
            BR_BGEZ: taken = !rs_neg;
            BR_BLEZ: taken = rs_neg || rs_zero;
            BR_BGTZ: taken = !rs_neg && !rs_zero;
            BR_BLTU: taken = rs_ltu_rt;
            BR_BGEU: taken = !rs_ltu_rt;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates conditional branches, registers the result
// behind a valid/ready handshake, trains a PC-indexed 2-bit BHT and counts
// mispredicts (saturating).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   pred_pc / pred_taken : fetch-side prediction lookup (combinational)
//   in_valid / in_ready  : request handshake
//   br_op, br_pc, rs_val, rt_val, pred_in : request payload
//   flush                : drop held result, block accept this cycle
//   out_valid / out_ready: result handshake
//   out_taken, out_mispredict, out_pc : result payload
//   mispredict_cnt       : saturating mispredict count
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PC_W-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       br_op,
    input  logic [PC_W-1:0]  br_pc,
    input  logic [XLEN-1:0]  rs_val,
    input  logic [XLEN-1:0]  rt_val,
    input  logic             pred_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_mispredict,
    output logic [PC_W-1:0]  out_pc,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = clog2(BHT_DEPTH);

    logic             taken;
    logic             mispredict;
    logic             accept;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;

    logic             out_valid_reg;
    logic             out_taken_reg;
    logic             out_mispredict_reg;
    logic [PC_W-1:0]  out_pc_reg;
    logic [CNT_W-1:0] cnt_reg;

    bht_ctr_t bht_reg  [BHT_DEPTH];
    bht_ctr_t bht_next [BHT_DEPTH];

    // Only the index slice of each PC is consumed; the rest is intentionally
    // dropped. Named so lint treats it as deliberately unused.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc, br_pc};

    branch_cond_eval #(
        .XLEN(XLEN)
    ) u_cond (
        .br_op (br_op),
        .rs_val(rs_val),
        .rt_val(rt_val),
        .taken (taken)
    );

    assign pred_idx   = pred_pc[IDX_W+1:2];
    assign upd_idx    = br_pc[IDX_W+1:2];
    assign mispredict = (taken != pred_in);

    // flush has priority over everything, including a pending drain.
    assign in_ready = !flush && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    // Read the registered entry directly: a same-cycle update is not bypassed.
    assign pred_taken = bht_reg[pred_idx][1];

    genvar gi;
    generate
        for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht_next
            assign bht_next[gi] = (accept && (upd_idx == IDX_W'(gi)))
                                  ? bht_step(bht_reg[gi], taken)
                                  : bht_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_reg[i] <= BHT_RESET;
            end
        end else begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_reg[i] <= bht_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg      <= 1'b0;
            out_taken_reg      <= 1'b0;
            out_mispredict_reg <= 1'b0;
            out_pc_reg         <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg      <= 1'b1;
            out_taken_reg      <= taken;
            out_mispredict_reg <= mispredict;
            out_pc_reg         <= br_pc;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (accept && mispredict && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign out_valid      = out_valid_reg;
    assign out_taken      = out_taken_reg;
    assign out_mispredict = out_mispredict_reg;
    assign out_pc         = out_pc_reg;
    assign mispredict_cnt = cnt_reg;

endmodule
